// File: rtl/keypad_bcd_entry.sv
// rtl/keypad_bcd_entry.sv - 4x4 matrix keypad scanner with debounce and two-digit BCD entry
module keypad_bcd_entry #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk_50MHz,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [7:0] value,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       load
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] PRESSED  = 2'd2;
   localparam logic [1:0] RELEASE  = 2'd3;

   logic [3:0]    row_meta, row_sync;
   logic [SW-1:0] slot_cnt;
   logic [1:0]    col_idx;
   logic [1:0]    acc_lows;
   logic [3:0]    acc_code;
   logic [1:0]    state, state_n;
   logic [3:0]    cand, cand_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          accept;

   logic          sample_now, frame_end, frame_none, frame_single;
   logic [2:0]    cur_lows, tot_lows;
   logic [3:0]    cur_code, frame_code;

   function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: key_at = 4'h1;  4'h1: key_at = 4'h2;  4'h2: key_at = 4'h3;  4'h3: key_at = 4'hA;
         4'h4: key_at = 4'h4;  4'h5: key_at = 4'h5;  4'h6: key_at = 4'h6;  4'h7: key_at = 4'hB;
         4'h8: key_at = 4'h7;  4'h9: key_at = 4'h8;  4'hA: key_at = 4'h9;  4'hB: key_at = 4'hC;
         4'hC: key_at = 4'h0;  4'hD: key_at = 4'hF;  4'hE: key_at = 4'hE;  default: key_at = 4'hD;
      endcase
   endfunction

   assign col        = ~(4'b0001 << col_idx);
   assign sample_now = (slot_cnt == SLOT_LAST);
   assign frame_end  = sample_now && (col_idx == 2'd3);

   // Current column's contribution merged with the columns already sampled this frame
   always_comb begin
      cur_lows = 3'd0;
      cur_code = 4'h0;
      for (int r = 0; r < 4; r++) begin
         if (!row_sync[r]) begin
            cur_lows = cur_lows + 3'd1;
            cur_code = key_at(2'(r), col_idx);
         end
      end
      tot_lows     = {1'b0, acc_lows} + cur_lows;
      frame_code   = (cur_lows != 3'd0) ? cur_code : acc_code;
      frame_none   = (tot_lows == 3'd0);
      frame_single = (tot_lows == 3'd1);
   end

   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      accept  = 1'b0;
      if (frame_end) begin
         case (state)
            IDLE: if (frame_single) begin
               cand_n = frame_code;
               cnt_n  = CNT_ONE;
               if (CNT_DONE == CNT_ONE) begin
                  accept  = 1'b1;
                  state_n = PRESSED;
               end else begin
                  state_n = DEBOUNCE;
               end
            end
            DEBOUNCE: if (frame_single && frame_code == cand) begin
               cnt_n = cnt + CNT_ONE;
               if (cnt_n == CNT_DONE) begin
                  accept  = 1'b1;
                  state_n = PRESSED;
               end
            end else if (frame_single) begin
               cand_n = frame_code;
               cnt_n  = CNT_ONE;
            end else begin
               state_n = IDLE;
            end
            PRESSED: if (frame_none) begin
               cnt_n   = CNT_ONE;
               state_n = (CNT_DONE == CNT_ONE) ? IDLE : RELEASE;
            end
            default: if (frame_none) begin
               cnt_n = cnt + CNT_ONE;
               if (cnt_n == CNT_DONE) state_n = IDLE;
            end else begin
               state_n = PRESSED;
            end
         endcase
      end
   end

   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         row_meta  <= 4'hF;
         row_sync  <= 4'hF;
         slot_cnt  <= '0;
         col_idx   <= 2'd0;
         acc_lows  <= 2'd0;
         acc_code  <= 4'h0;
         state     <= IDLE;
         cand      <= 4'h0;
         cnt       <= '0;
         value     <= 8'h00;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         load      <= 1'b0;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
         if (sample_now) begin
            slot_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            if (col_idx == 2'd3) begin
               acc_lows <= 2'd0;
               acc_code <= 4'h0;
            end else begin
               acc_lows <= (tot_lows >= 3'd2) ? 2'd2 : tot_lows[1:0];
               acc_code <= frame_code;
            end
         end else begin
            slot_cnt <= slot_cnt + SW'(1);
         end
         state     <= state_n;
         cand      <= cand_n;
         cnt       <= cnt_n;
         key_valid <= accept;
         load      <= accept && (cand_n == 4'hF);
         if (accept) begin
            key_code <= cand_n;
            if (cand_n <= 4'd9) value <= {value[3:0], cand_n};
            else if (cand_n == 4'hA) value <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// tb/tb_keypad_bcd_entry.sv - scoreboard bench for keypad_bcd_entry with a frame-level reference model
module tb_keypad_bcd_entry;

   localparam int SCAN_DIV = 8;
   localparam int DS       = 3;
   localparam int FRAME    = 4 * SCAN_DIV;
   localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                       4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

   typedef struct packed {
      logic [3:0] code;
      logic [7:0] value;
      logic       load;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  row, col, key_code;
   logic [7:0]  value;
   logic        key_valid, load;
   logic [15:0] keys = '0;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   bit          prev_kv = 1'b0;

   bit          armed;
   int          same_run, none_run;
   logic [3:0]  last_code;
   logic [7:0]  m_value;

   always #5 clk = ~clk;

   keypad_bcd_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
      .clk_50MHz (clk),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .value     (value),
      .key_code  (key_code),
      .key_valid (key_valid),
      .load      (load)
   );

   // Physical keypad: a pressed key pulls its row low while its column is driven low
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Press accepted after DS identical single-key frames while armed; re-armed after DS empty frames
   task automatic model_frame(input logic [15:0] m);
      int   n;
      int   idx;
      logic [3:0] code;
      exp_t e;
      n = $countones(m);
      idx = 0;
      for (int i = 0; i < 16; i++) if (m[i]) idx = i;
      code = KMAP[idx];
      if (armed) begin
         if (n == 1) begin
            if (same_run > 0 && code == last_code) same_run++;
            else same_run = 1;
            last_code = code;
            if (same_run == DS) begin
               armed = 1'b0;
               none_run = 0;
               if (code <= 4'd9) m_value = {m_value[3:0], code};
               else if (code == 4'hA) m_value = 8'h00;
               e.code  = code;
               e.value = m_value;
               e.load  = (code == 4'hF);
               exp_q.push_back(e);
            end
         end else begin
            same_run = 0;
         end
      end else begin
         if (n == 0) begin
            none_run++;
            if (none_run == DS) begin
               armed = 1'b1;
               same_run = 0;
            end
         end else begin
            none_run = 0;
         end
      end
   endtask

   task automatic run_frame(input logic [15:0] m);
      logic [3:0] exp_col;
      chk("value_hold", value, m_value);
      model_frame(m);
      keys = m;
      for (int k = 0; k < FRAME; k++) begin
         exp_col = ~(4'b0001 << (k / SCAN_DIV));
         chk("col_scan", col, exp_col);
         @(negedge clk);
      end
   endtask

   task automatic hold(input logic [15:0] m, input int n);
      repeat (n) run_frame(m);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      armed = 1'b1;
      same_run = 0;
      none_run = 0;
      last_code = 4'h0;
      m_value = 8'h00;
      chk("rst_col", col, 4'b1110);
      chk("rst_value", value, 8'h00);
      chk("rst_key_code", key_code, 4'h0);
      chk("rst_key_valid", key_valid, 1'b0);
      chk("rst_load", load, 1'b0);
   endtask

   function automatic logic [15:0] key_mask(input int pos);
      logic [15:0] one;
      one = 16'h0001;
      return one << pos;
   endfunction

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (load) chk("load_without_valid", key_valid, 1'b1);
            if (key_valid) begin
               chk("valid_width", prev_kv, 1'b0);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_key actual=key_code %0h value %0h required=no pulse", key_code, value);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("key_code", key_code, e.code);
                  chk("value", value, e.value);
                  chk("load", load, e.load);
               end
            end
            prev_kv = key_valid;
         end
      join_none

      do_reset();
      hold(16'h0000, 1);

      hold(key_mask(5), 5);
      hold(16'h0000, 4);
      hold(key_mask(8), 4);
      hold(16'h0000, 4);

      hold(key_mask(13), 4);
      hold(16'h0000, 4);
      hold(key_mask(3), 4);
      hold(16'h0000, 4);

      repeat (3) begin
         run_frame(key_mask(10));
         run_frame(16'h0000);
      end
      hold(key_mask(10), 4);
      hold(16'h0000, 4);

      hold(key_mask(0) | key_mask(1), 6);
      hold(16'h0000, 4);

      hold(key_mask(2), 5);
      do_reset();
      hold(key_mask(2), 4);
      hold(16'h0000, 4);

      repeat (24) begin
         int sel;
         int a;
         int b;
         sel = $urandom_range(0, 9);
         a = $urandom_range(0, 15);
         b = (a + $urandom_range(1, 15)) % 16;
         if (sel < 6) hold(key_mask(a), $urandom_range(1, 6));
         else if (sel < 8) hold(16'h0000, $urandom_range(1, 5));
         else hold(key_mask(a) | key_mask(b), $urandom_range(1, 3));
      end

      hold(16'h0000, 4);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
